// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like arbiter.
//   arb_id_e     : owner tag stored in the ID FIFO (inst = 0, data = 1)
//   sram_size_e  : transfer size encoding on the sram-like bus
//   arb_state_e  : address-phase lock state
package sram_like_arbiter_pkg;

    typedef enum logic {
        ARB_ID_INST = 1'b0,
        ARB_ID_DATA = 1'b1
    } arb_id_e;

    typedef enum logic [1:0] {
        SRAM_SIZE_B = 2'd0,
        SRAM_SIZE_H = 2'd1,
        SRAM_SIZE_W = 2'd2
    } sram_size_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sram_like_arbiter_arb_id_fifo.sv
// arb_id_fifo: in-order 1-bit owner-ID FIFO for the sram-like arbiter.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_id     enqueue owner ID (ignored when full)
//   pop               dequeue head (ignored when empty)
//   full, empty       occupancy flags
//   head              owner ID of the oldest outstanding transaction
module arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    // Pointer advance modulo DEPTH (also correct for DEPTH == 1).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == CNT_W'(0));
    assign head  = mem_q[rd_ptr_q];

    // Next-state computation for storage, pointers and occupancy count.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like memory port between the instruction
// requester (inst_sram_*) and the data requester (data_sram_*).
// One address phase is granted per cycle; the owner of each accepted request is
// queued in an in-order ID FIFO and used to steer data_ok/rdata back.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   inst_sram_* / data_sram_*  requester side (req/wr/size/addr/wstrb/wdata in,
//                          addrok/dataok/rdata out)
//   mem_*                  slave side (request payload out, addrok/dataok/rdata in)
//   arb_err                sticky: response arrived with no outstanding request
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin grant; default is fixed
// priority with data over inst).
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addrok,
    output logic        data_sram_dataok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addrok,
    input  logic        mem_dataok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    arb_state_e state_q, state_d;
    arb_id_e    owner_q, owner_d;
    arb_id_e    grant;
    logic       req_sel;
    logic       req_ok;
    logic       handshake;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       fifo_pop;
    logic       arb_err_q, arb_err_d;

`ifdef ARB_ROUND_ROBIN_EN
    arb_id_e    rr_q, rr_d;

    // Round-robin grant; a locked address phase keeps its owner.
    always_comb begin
        if (state_q == ST_LOCKED) begin
            grant = owner_q;
        end else if (inst_sram_req && data_sram_req) begin
            grant = rr_q;
        end else if (data_sram_req) begin
            grant = ARB_ID_DATA;
        end else begin
            grant = ARB_ID_INST;
        end
    end

    // Pointer moves to the other requester after every address handshake.
    always_comb begin
        if (handshake) begin
            rr_d = (grant == ARB_ID_INST) ? ARB_ID_DATA : ARB_ID_INST;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= ARB_ID_INST;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed-priority grant (data over inst); a locked address phase keeps its owner.
    always_comb begin
        if (state_q == ST_LOCKED) begin
            grant = owner_q;
        end else if (data_sram_req) begin
            grant = ARB_ID_DATA;
        end else begin
            grant = ARB_ID_INST;
        end
    end
`endif

    // A full FIFO blocks the request even if a response pops an entry this cycle,
    // which keeps mem_req free of any path from mem_dataok.
    assign req_sel   = (grant == ARB_ID_DATA) ? data_sram_req : inst_sram_req;
    assign req_ok    = req_sel & ~fifo_full;
    assign handshake = req_ok & mem_addrok;
    assign fifo_pop  = mem_dataok & ~fifo_empty;

    // Lock FSM: an offered but unaccepted address phase pins the grant.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ok && !mem_addrok) begin
                    state_d = ST_LOCKED;
                    owner_d = grant;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // Also release if the requester withdrew, so the grant cannot stick.
                if (!req_ok || mem_addrok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = ARB_ID_INST;
            end
        endcase
    end

    // Sticky error on a response that has no outstanding owner.
    always_comb begin
        if (mem_dataok && fifo_empty) begin
            arb_err_d = 1'b1;
        end else begin
            arb_err_d = arb_err_q;
        end
    end

    // Lock state, owner and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= ARB_ID_INST;
            arb_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            arb_err_q <= arb_err_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (handshake),
        .push_id (grant),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Output mux and response steering; forced to 0 while reset is asserted.
    always_comb begin
        mem_req          = 1'b0;
        mem_wr           = 1'b0;
        mem_size         = 2'd0;
        mem_addr         = 32'd0;
        mem_wstrb        = 4'd0;
        mem_wdata        = 32'd0;
        inst_sram_addrok = 1'b0;
        data_sram_addrok = 1'b0;
        inst_sram_dataok = 1'b0;
        data_sram_dataok = 1'b0;
        inst_sram_rdata  = 32'd0;
        data_sram_rdata  = 32'd0;
        arb_err          = 1'b0;
        if (!reset) begin
            mem_req = req_ok;
            if (grant == ARB_ID_DATA) begin
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_addr  = data_sram_addr;
                mem_wstrb = data_sram_wstrb;
                mem_wdata = data_sram_wdata;
            end else begin
                mem_wr    = inst_sram_wr;
                mem_size  = inst_sram_size;
                mem_addr  = inst_sram_addr;
                mem_wstrb = inst_sram_wstrb;
                mem_wdata = inst_sram_wdata;
            end
            inst_sram_addrok = handshake & (grant == ARB_ID_INST);
            data_sram_addrok = handshake & (grant == ARB_ID_DATA);
            inst_sram_dataok = fifo_pop & (fifo_head == ARB_ID_INST);
            data_sram_dataok = fifo_pop & (fifo_head == ARB_ID_DATA);
            inst_sram_rdata  = mem_rdata;
            data_sram_rdata  = mem_rdata;
            arb_err          = arb_err_q;
        end else begin
            mem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed testbench for sram_like_arbiter (MAX_OUTST = 2).
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic [3:0]  inst_sram_wstrb;
    logic        inst_sram_addrok, inst_sram_dataok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_wstrb;
    logic        data_sram_addrok, data_sram_dataok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addrok, mem_dataok;
    logic [31:0] mem_rdata;
    logic        arb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTST(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_wr     (inst_sram_wr),
        .inst_sram_size   (inst_sram_size),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wstrb  (inst_sram_wstrb),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_addrok (inst_sram_addrok),
        .inst_sram_dataok (inst_sram_dataok),
        .inst_sram_rdata  (inst_sram_rdata),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wstrb  (data_sram_wstrb),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_addrok (data_sram_addrok),
        .data_sram_dataok (data_sram_dataok),
        .data_sram_rdata  (data_sram_rdata),
        .mem_req          (mem_req),
        .mem_wr           (mem_wr),
        .mem_size         (mem_size),
        .mem_addr         (mem_addr),
        .mem_wstrb        (mem_wstrb),
        .mem_wdata        (mem_wdata),
        .mem_addrok       (mem_addrok),
        .mem_dataok       (mem_dataok),
        .mem_rdata        (mem_rdata),
        .arb_err          (arb_err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, still well before the next rising edge.
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
        inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
        data_sram_addr = 32'd0; data_sram_wstrb = 4'd0; data_sram_wdata = 32'd0;
        mem_addrok = 1'b0; mem_dataok = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        // Reset: outputs forced to 0 even with live inputs.
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00000;
        mem_addrok = 1'b1; mem_dataok = 1'b1; mem_rdata = 32'hDEADBEEF;
        settle();
        chk1 ("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk1 ("rst_inst_addrok", inst_sram_addrok, 1'b0);
        chk1 ("rst_inst_dataok", inst_sram_dataok, 1'b0);
        chk32("rst_inst_rdata", inst_sram_rdata, 32'd0);
        chk1 ("rst_arb_err", arb_err, 1'b0);
        tick();
        idle_inputs();
        reset = 1'b0;
        tick();

        // 1: lone inst request, response two cycles later.
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00000; inst_sram_size = 2'd2;
        mem_addrok = 1'b1;
        settle();
        chk1 ("t1_mem_req", mem_req, 1'b1);
        chk32("t1_mem_addr", mem_addr, 32'hBFC00000);
        chk32("t1_mem_size", {30'd0, mem_size}, 32'd2);
        chk1 ("t1_inst_addrok", inst_sram_addrok, 1'b1);
        chk1 ("t1_data_addrok", data_sram_addrok, 1'b0);
        tick();
        inst_sram_req = 1'b0; mem_addrok = 1'b0;
        tick();
        mem_dataok = 1'b1; mem_rdata = 32'h24020001;
        settle();
        chk1 ("t1_inst_dataok", inst_sram_dataok, 1'b1);
        chk32("t1_inst_rdata", inst_sram_rdata, 32'h24020001);
        chk1 ("t1_data_dataok", data_sram_dataok, 1'b0);
        tick();
        mem_dataok = 1'b0;
        settle();
        chk1 ("t1_arb_err", arb_err, 1'b0);

`ifndef ARB_ROUND_ROBIN_EN
        // 2: simultaneous requests, data wins first; responses return in order.
        tick();
        pulse_reset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00004;
        data_sram_req = 1'b1; data_sram_addr = 32'h80001000;
        mem_addrok = 1'b1;
        settle();
        chk32("t2_first_addr", mem_addr, 32'h80001000);
        chk1 ("t2_first_data_addrok", data_sram_addrok, 1'b1);
        chk1 ("t2_first_inst_addrok", inst_sram_addrok, 1'b0);
        tick();
        data_sram_req = 1'b0;
        settle();
        chk32("t2_second_addr", mem_addr, 32'hBFC00004);
        chk1 ("t2_second_inst_addrok", inst_sram_addrok, 1'b1);
        tick();
        inst_sram_req = 1'b0; mem_addrok = 1'b0;
        mem_dataok = 1'b1; mem_rdata = 32'h11111111;
        settle();
        chk1 ("t2_resp1_data", data_sram_dataok, 1'b1);
        chk1 ("t2_resp1_inst", inst_sram_dataok, 1'b0);
        chk32("t2_resp1_rdata", data_sram_rdata, 32'h11111111);
        tick();
        mem_rdata = 32'h22222222;
        settle();
        chk1 ("t2_resp2_inst", inst_sram_dataok, 1'b1);
        chk1 ("t2_resp2_data", data_sram_dataok, 1'b0);
        tick();
        mem_dataok = 1'b0;
`endif

        // 3a: data held off by the slave; a later inst request must not steal the grant.
        tick();
        pulse_reset();
        data_sram_req = 1'b1; data_sram_addr = 32'h80002000;
        settle();
        chk1 ("t3a_mem_req", mem_req, 1'b1);
        chk32("t3a_addr_c0", mem_addr, 32'h80002000);
        tick();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00008;
        settle();
        chk32("t3a_addr_c1", mem_addr, 32'h80002000);
        chk1 ("t3a_inst_addrok_c1", inst_sram_addrok, 1'b0);
        tick();
        mem_addrok = 1'b1;
        settle();
        chk32("t3a_addr_c2", mem_addr, 32'h80002000);
        chk1 ("t3a_data_addrok", data_sram_addrok, 1'b1);
        tick();
        idle_inputs();

        // 3b: inst held off; a later data request must not steal the grant.
        tick();
        pulse_reset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00010;
        settle();
        chk32("t3b_addr_c0", mem_addr, 32'hBFC00010);
        tick();
        data_sram_req = 1'b1; data_sram_addr = 32'h80003000;
        settle();
        chk32("t3b_addr_c1", mem_addr, 32'hBFC00010);
        chk1 ("t3b_data_addrok_c1", data_sram_addrok, 1'b0);
        tick();
        settle();
        chk32("t3b_addr_c2", mem_addr, 32'hBFC00010);
        mem_addrok = 1'b1;
        settle();
        chk1 ("t3b_inst_addrok", inst_sram_addrok, 1'b1);
        chk1 ("t3b_data_addrok_c2", data_sram_addrok, 1'b0);
        tick();
        inst_sram_req = 1'b0;
        settle();
        chk32("t3b_addr_after", mem_addr, 32'h80003000);
        chk1 ("t3b_data_addrok_after", data_sram_addrok, 1'b1);
        tick();
        idle_inputs();

        // 4: FIFO full blocks requests, including in a pop cycle.
        tick();
        pulse_reset();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00020; mem_addrok = 1'b1;
        settle();
        chk1 ("t4_push1_addrok", inst_sram_addrok, 1'b1);
        tick();
        inst_sram_addr = 32'hBFC00024;
        settle();
        chk1 ("t4_push2_addrok", inst_sram_addrok, 1'b1);
        tick();
        inst_sram_addr = 32'hBFC00028;
        settle();
        chk1 ("t4_full_mem_req", mem_req, 1'b0);
        chk1 ("t4_full_addrok", inst_sram_addrok, 1'b0);
        tick();
        mem_dataok = 1'b1; mem_rdata = 32'hA0A0A0A0;
        settle();
        chk1 ("t4_pop_cycle_mem_req", mem_req, 1'b0);
        chk1 ("t4_pop_cycle_addrok", inst_sram_addrok, 1'b0);
        chk1 ("t4_pop_cycle_dataok", inst_sram_dataok, 1'b1);
        tick();
        mem_dataok = 1'b0;
        settle();
        chk1 ("t4_after_pop_mem_req", mem_req, 1'b1);
        chk1 ("t4_after_pop_addrok", inst_sram_addrok, 1'b1);
        tick();
        inst_sram_req = 1'b0; mem_addrok = 1'b0; mem_dataok = 1'b1;
        settle();
        chk1 ("t4_drain1", inst_sram_dataok, 1'b1);
        tick();
        settle();
        chk1 ("t4_drain2", inst_sram_dataok, 1'b1);
        chk1 ("t4_no_err", arb_err, 1'b0);
        tick();
        mem_dataok = 1'b0;

        // 5: response with an empty FIFO.
        tick();
        mem_dataok = 1'b1; mem_rdata = 32'h55555555;
        settle();
        chk1 ("t5_inst_dataok", inst_sram_dataok, 1'b0);
        chk1 ("t5_data_dataok", data_sram_dataok, 1'b0);
        chk1 ("t5_err_before_edge", arb_err, 1'b0);
        tick();
        mem_dataok = 1'b0;
        settle();
        chk1 ("t5_err_set", arb_err, 1'b1);
        tick();
        tick();
        settle();
        chk1 ("t5_err_sticky", arb_err, 1'b1);
        pulse_reset();
        settle();
        chk1 ("t5_err_cleared", arb_err, 1'b0);

        // 6: both requesting continuously, slave answering every cycle.
        tick();
        inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00100;
        data_sram_req = 1'b1; data_sram_addr = 32'h80004000;
        mem_addrok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_inst;
`ifdef ARB_ROUND_ROBIN_EN
            exp_inst = ((i % 2) == 0);
`else
            exp_inst = 1'b0;
`endif
            mem_dataok = (i > 0);
            settle();
            chk1 ($sformatf("t6_inst_addrok_%0d", i), inst_sram_addrok, exp_inst);
            chk1 ($sformatf("t6_data_addrok_%0d", i), data_sram_addrok, ~exp_inst);
            tick();
        end
        // Asynchronous reset in the middle of the burst.
        #1;
        reset = 1'b1;
        #1;
        chk1 ("t6_rst_mem_req", mem_req, 1'b0);
        chk32("t6_rst_mem_addr", mem_addr, 32'd0);
        chk1 ("t6_rst_inst_addrok", inst_sram_addrok, 1'b0);
        chk1 ("t6_rst_data_addrok", data_sram_addrok, 1'b0);
        chk1 ("t6_rst_data_dataok", data_sram_dataok, 1'b0);
        tick();
        idle_inputs();
        reset = 1'b0;
        // A stale response after reset proves the FIFO was emptied.
        mem_dataok = 1'b1;
        settle();
        chk1 ("t6_stale_inst_dataok", inst_sram_dataok, 1'b0);
        chk1 ("t6_stale_data_dataok", data_sram_dataok, 1'b0);
        tick();
        mem_dataok = 1'b0;
        settle();
        chk1 ("t6_stale_err", arb_err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
